// File: rtl/fixed_point_arith.sv
// -----------------------------------------------------------------------------
// fixed_point_arith
//   Two-stage pipelined signed fixed-point arithmetic unit. For every valid
//   operand pair it produces:
//   - the full-precision sum and product
//   - the sum saturated to a signed 4-bit range
//   - the sum divided by 8 with round-half-up, saturated to WORD_LENGTH-2 bits
//   It accepts one operation per clock and has no backpressure.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset; clears every pipeline register
//   valid_i        a/b are valid this cycle
//   a, b           signed operands, WORD_LENGTH bits
//   c_add          a+b, WORD_LENGTH+1 bits
//   c_mult         a*b, 2*WORD_LENGTH bits
//   c_clipped_add  a+b saturated to [-8,7]
//   c_round_add    round((a+b)/8), saturated to [-2^(WL-3), 2^(WL-3)-1]
//   valid_o        valid_i delayed by two clocks
//
// Results are registered only in valid slots. In an invalid slot they hold
// their previous value.
// -----------------------------------------------------------------------------
module fixed_point_arith #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valid_i,
  input  logic signed [WORD_LENGTH-1:0]   a,
  input  logic signed [WORD_LENGTH-1:0]   b,
  output logic signed [WORD_LENGTH:0]     c_add,
  output logic signed [2*WORD_LENGTH-1:0] c_mult,
  output logic signed [3:0]               c_clipped_add,
  output logic signed [WORD_LENGTH-3:0]   c_round_add,
  output logic                            valid_o
);

  localparam int WL = WORD_LENGTH;

  localparam logic signed [WL:0]   CLIP_MAX  = (WL+1)'(7);
  localparam logic signed [WL:0]   CLIP_MIN  = (WL+1)'(-8);
  localparam logic signed [WL+1:0] ROUND_MAX = (WL+2)'((2 ** (WL-3)) - 1);
  localparam logic signed [WL+1:0] ROUND_MIN = (WL+2)'(-(2 ** (WL-3)));
  localparam logic signed [WL+1:0] HALF_LSB  = (WL+2)'(4);

  // Saturate the full-precision sum to a signed 4-bit result.
  function automatic logic signed [3:0] sat_clip4(input logic signed [WL:0] s);
    logic signed [3:0] res;
    if (s > CLIP_MAX)       res = 4'sd7;
    else if (s < CLIP_MIN)  res = -4'sd8;
    else                    res = s[3:0];
    return res;
  endfunction

  // Divide by 8 with round-half-up (bias of +4, then an arithmetic shift),
  // then saturate. The sum is widened by one bit first, so adding the bias
  // cannot wrap.
  function automatic logic signed [WL-3:0] round_sat(input logic signed [WL:0] s);
    logic signed [WL+1:0] t;
    logic signed [WL+1:0] r;
    logic signed [WL-3:0] res;
    t = s;
    t = t + HALF_LSB;
    r = t >>> 3;
    if (r > ROUND_MAX)      res = ROUND_MAX[WL-3:0];
    else if (r < ROUND_MIN) res = ROUND_MIN[WL-3:0];
    else                    res = r[WL-3:0];
    return res;
  endfunction

  logic signed [WL-1:0]   a_p1_d, a_p1_q;
  logic signed [WL-1:0]   b_p1_d, b_p1_q;
  logic                   vld_p1_d, vld_p1_q;

  logic signed [WL:0]     add_p2_d, add_p2_q;
  logic signed [2*WL-1:0] mult_p2_d, mult_p2_q;
  logic signed [3:0]      clip_p2_d, clip_p2_q;
  logic signed [WL-3:0]   rnd_p2_d, rnd_p2_q;
  logic                   vld_p2_d, vld_p2_q;

  logic signed [WL:0]     a_ext_sum, b_ext_sum, sum;
  logic signed [2*WL-1:0] a_ext_mul, b_ext_mul;

  always_comb begin
    // Stage 1: capture operands and valid
    a_p1_d    = a;
    b_p1_d    = b;
    vld_p1_d  = valid_i;

    // Stage 2: compute from the stage-1 registers
    a_ext_sum = a_p1_q;
    b_ext_sum = b_p1_q;
    sum       = a_ext_sum + b_ext_sum;
    a_ext_mul = a_p1_q;
    b_ext_mul = b_p1_q;

    vld_p2_d  = vld_p1_q;
    add_p2_d  = add_p2_q;
    mult_p2_d = mult_p2_q;
    clip_p2_d = clip_p2_q;
    rnd_p2_d  = rnd_p2_q;
    if (vld_p1_q) begin
      add_p2_d  = sum;
      mult_p2_d = a_ext_mul * b_ext_mul;
      clip_p2_d = sat_clip4(sum);
      rnd_p2_d  = round_sat(sum);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p1_q    <= '0;
      b_p1_q    <= '0;
      vld_p1_q  <= 1'b0;
      add_p2_q  <= '0;
      mult_p2_q <= '0;
      clip_p2_q <= '0;
      rnd_p2_q  <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      a_p1_q    <= a_p1_d;
      b_p1_q    <= b_p1_d;
      vld_p1_q  <= vld_p1_d;
      add_p2_q  <= add_p2_d;
      mult_p2_q <= mult_p2_d;
      clip_p2_q <= clip_p2_d;
      rnd_p2_q  <= rnd_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign c_add         = add_p2_q;
  assign c_mult        = mult_p2_q;
  assign c_clipped_add = clip_p2_q;
  assign c_round_add   = rnd_p2_q;
  assign valid_o       = vld_p2_q;

endmodule

// File: tb/tb_fixed_point_arith.sv
module tb_fixed_point_arith;

  localparam int WL = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   valid_i;
  logic signed [WL-1:0]   a, b;
  logic signed [WL:0]     c_add;
  logic signed [2*WL-1:0] c_mult;
  logic signed [3:0]      c_clipped_add;
  logic signed [WL-3:0]   c_round_add;
  logic                   valid_o;

  fixed_point_arith #(.WORD_LENGTH(WL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_i       (valid_i),
    .a             (a),
    .b             (b),
    .c_add         (c_add),
    .c_mult        (c_mult),
    .c_clipped_add (c_clipped_add),
    .c_round_add   (c_round_add),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int add;
    int mult;
    int clip;
    int rnd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int   s, t, q, lim;
    s      = x + y;
    e.add  = s;
    e.mult = x * y;
    e.clip = (s > 7) ? 7 : ((s < -8) ? -8 : s);
    t      = s + 4;
    q      = (t >= 0) ? (t / 8) : -((-t + 7) / 8);
    lim    = 2 ** (WL - 3);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim)    q = -lim;
    e.rnd  = q;
    return e;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    valid_i = 1'b0;
    a = WL'($urandom);
    b = WL'($urandom);
  endtask

  task automatic issue(input int x, input int y);
    @(posedge clk); #1;
    valid_i = 1'b1;
    a = WL'(x);
    b = WL'(y);
    exp_q.push_back(model(x, y));
  endtask

  function automatic int rand_op();
    int pick;
    pick = int'($urandom_range(0, 9));
    case (pick)
      0: return -(2 ** (WL-1));
      1: return (2 ** (WL-1)) - 1;
      2: return 0;
      default: return int'($urandom_range(0, (2 ** WL) - 1)) - (2 ** (WL-1));
    endcase
  endfunction

  // Monitor: pops and compares on valid_o. In invalid slots it checks that
  // the results held their last value.
  exp_t hold_exp = '{0, 0, 0, 0};
  always begin
    exp_t e;
    @(negedge clk);
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_o", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("c_add",         int'(c_add),         e.add);
        chk("c_mult",        int'(c_mult),        e.mult);
        chk("c_clipped_add", int'(c_clipped_add), e.clip);
        chk("c_round_add",   int'(c_round_add),   e.rnd);
        hold_exp = e;
      end
    end else begin
      chk("hold_c_add",   int'(c_add),         hold_exp.add);
      chk("hold_c_mult",  int'(c_mult),        hold_exp.mult);
      chk("hold_clipped", int'(c_clipped_add), hold_exp.clip);
      chk("hold_round",   int'(c_round_add),   hold_exp.rnd);
    end
    // Reset is seen here before its edge: everything still in flight is dropped.
    if (!rst_n) begin
      exp_q.delete();
      hold_exp = '{0, 0, 0, 0};
    end
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    a       = '0;
    b       = '0;
    repeat (3) idle();
    @(posedge clk); #1;
    chk("reset_valid_o", int'(valid_o), 0);
    chk("reset_c_add",   int'(c_add),   0);
    rst_n = 1'b1;

    // Directed vectors
    issue(-128, 127);
    idle();
    issue(127, -128);
    issue(-128, -128);
    idle();
    idle();
    issue(-120, 11);
    issue(84, 25);
    issue(127, 127);
    issue(-1, -3);
    issue(3, 0);
    issue(4, 0);
    issue(-4, 0);
    issue(-5, 0);
    repeat (3) idle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7) issue(rand_op(), rand_op());
      else idle();
    end
    repeat (3) idle();

    // Mid-stream reset: three back-to-back ops, then reset for one edge
    issue(100, 27);
    issue(-77, 5);
    issue(-128, -128);
    @(posedge clk); #1;
    valid_i = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk); #1;
    chk("rst_valid_o", int'(valid_o),       0);
    chk("rst_c_add",   int'(c_add),         0);
    chk("rst_c_mult",  int'(c_mult),        0);
    chk("rst_clipped", int'(c_clipped_add), 0);
    chk("rst_round",   int'(c_round_add),   0);
    rst_n = 1'b1;
    repeat (5) idle();

    // A few more ops after reset
    issue(-120, 11);
    issue(127, 127);
    repeat (4) idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
